// File: rtl/matrix_piso_pkg.sv
// Shared constants, FSM state encoding and width helper for the result-matrix
// PISO streamer.
package matrix_piso_pkg;

   // Defaults match the matmul result register bank geometry.
   localparam int DEF_DATA_W = 32;
   localparam int DEF_MAX_M  = 100;
   localparam int DEF_MAX_N  = 100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } piso_state_e;

   // Bits needed to hold values 0..max_v, never less than one.
   function automatic int cnt_w(input int max_v);
      return (max_v < 2) ? 1 : $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/matrix_piso_lane_mux.sv
// Combinational LANES-wide gather from the flat C-matrix. Lanes walk columns
// of one row, or rows of one column when i_col_major is set.
module matrix_piso_lane_mux
   import matrix_piso_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int MAX_M  = DEF_MAX_M,
   parameter int MAX_N  = DEF_MAX_N,
   parameter int LANES  = 1,
   parameter int CW     = 8
) (
   input  logic [MAX_M*MAX_N*DATA_W-1:0] i_matrix,
   input  logic [CW-1:0]                 i_row,
   input  logic [CW-1:0]                 i_col,
   input  logic [CW-1:0]                 i_m,
   input  logic [CW-1:0]                 i_n,
   input  logic                          i_col_major,
   output logic [LANES*DATA_W-1:0]       o_data,
   output logic [LANES-1:0]              o_keep
);

   localparam int AW = cnt_w(MAX_M * MAX_N - 1);

   logic [DATA_W-1:0] w_elem [MAX_M*MAX_N];

   for (genvar e = 0; e < MAX_M * MAX_N; e++) begin : g_elem
      assign w_elem[e] = i_matrix[e*DATA_W +: DATA_W];
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [CW-1:0] w_r;
      logic [CW-1:0] w_c;
      logic          w_keep;
      logic [AW-1:0] w_addr;

      assign w_r    = i_col_major ? i_row + CW'(i) : i_row;
      assign w_c    = i_col_major ? i_col : i_col + CW'(i);
      assign w_keep = i_col_major ? (w_r < i_m) : (w_c < i_n);
      assign w_addr = AW'(w_r) * AW'(MAX_N) + AW'(w_c);
      // Masked lanes may address past the array; the keep mux hides that.
      assign o_keep[i]                 = w_keep;
      assign o_data[i*DATA_W +: DATA_W] = w_keep ? w_elem[w_addr] : '0;
   end

endmodule

// File: rtl/matrix_piso_stream.sv
// Streams an M x N sub-block of the C-matrix as LANES-wide valid/ready beats.
// Define COL_MAJOR_EN to add the col_major port and column-order walking.
module matrix_piso_stream
   import matrix_piso_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int MAX_M  = DEF_MAX_M,
   parameter int MAX_N  = DEF_MAX_N,
   parameter int LANES  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(MAX_M+1)-1:0]    cfg_m,
   input  logic [$clog2(MAX_N+1)-1:0]    cfg_n,
   input  logic [MAX_M*MAX_N*DATA_W-1:0] matrix_C,
`ifdef COL_MAJOR_EN
   input  logic                          col_major,
`endif
   output logic [LANES*DATA_W-1:0]       out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0]              out_keep,
   output logic                          out_eol,
   output logic                          out_last,
   output logic                          busy,
   output logic                          done,
   output logic                          cfg_err
);

   localparam int MW   = $clog2(MAX_M + 1);
   localparam int NW   = $clog2(MAX_N + 1);
   localparam int MAXD = (MAX_M > MAX_N) ? MAX_M : MAX_N;
   // Wide enough that inner + LANES never wraps.
   localparam int CW   = cnt_w(MAXD + LANES);

   localparam logic [1:0] IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] STREAM = 2'(ST_STREAM);
   localparam logic [1:0] FLUSH  = 2'(ST_FLUSH);

   logic [1:0]              r_state;
   logic [CW-1:0]           r_m, r_n, r_outer, r_inner;
   logic [LANES*DATA_W-1:0] r_data;
   logic [LANES-1:0]        r_keep;
   logic                    r_valid, r_eol, r_last, r_busy, r_done, r_err;

   logic                    w_cm, w_cm_in, w_start_ok, w_hs, w_load;
   logic [CW-1:0]           w_in_lim, w_out_lim;
   logic [CW-1:0]           w_nxt_inner, w_nxt_outer, w_ld_inner, w_ld_outer;
   logic [CW-1:0]           w_row, w_col;
   logic                    w_ld_eol, w_ld_last;
   logic [LANES*DATA_W-1:0] w_lane_data;
   logic [LANES-1:0]        w_lane_keep;

`ifdef COL_MAJOR_EN
   logic r_cm;
   always_ff @(posedge clk) begin
      if (rst)                                r_cm <= 1'b0;
      else if (r_state == IDLE && w_start_ok) r_cm <= col_major;
   end
   assign w_cm    = r_cm;
   assign w_cm_in = col_major;
`else
   assign w_cm    = 1'b0;
   assign w_cm_in = 1'b0;
`endif

   assign w_start_ok = start && (cfg_m != '0) && (cfg_n != '0) &&
                       (cfg_m <= MW'(MAX_M)) && (cfg_n <= NW'(MAX_N));

   // Inner index advances by LANES inside a row (or column); outer steps on eol.
   assign w_in_lim    = w_cm ? r_m : r_n;
   assign w_out_lim   = w_cm ? r_n : r_m;
   assign w_hs        = r_valid && out_ready;
   assign w_nxt_inner = r_eol ? '0 : r_inner + CW'(LANES);
   assign w_nxt_outer = r_eol ? r_outer + CW'(1) : r_outer;
   assign w_ld_inner  = r_valid ? w_nxt_inner : r_inner;
   assign w_ld_outer  = r_valid ? w_nxt_outer : r_outer;
   assign w_ld_eol    = (w_ld_inner + CW'(LANES)) >= w_in_lim;
   assign w_ld_last   = w_ld_eol && (w_ld_outer == w_out_lim - CW'(1));
   assign w_row       = w_cm ? w_ld_inner : w_ld_outer;
   assign w_col       = w_cm ? w_ld_outer : w_ld_inner;
   assign w_load      = (r_state == STREAM) && (!r_valid || (w_hs && !r_last));

   matrix_piso_lane_mux #(
      .DATA_W (DATA_W),
      .MAX_M  (MAX_M),
      .MAX_N  (MAX_N),
      .LANES  (LANES),
      .CW     (CW)
   ) u_mux (
      .i_matrix    (matrix_C),
      .i_row       (w_row),
      .i_col       (w_col),
      .i_m         (r_m),
      .i_n         (r_n),
      .i_col_major (w_cm),
      .o_data      (w_lane_data),
      .o_keep      (w_lane_keep)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_m     <= '0;
         r_n     <= '0;
         r_outer <= '0;
         r_inner <= '0;
         r_data  <= '0;
         r_keep  <= '0;
         r_valid <= 1'b0;
         r_eol   <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_m     <= CW'(cfg_m);
                  r_n     <= CW'(cfg_n);
                  r_outer <= '0;
                  r_inner <= '0;
                  r_busy  <= 1'b1;
                  r_state <= STREAM;
               end else if (start) begin
                  r_err <= 1'b1;
               end
            end
            STREAM: begin
               if (w_load) begin
                  r_data  <= w_lane_data;
                  r_keep  <= w_lane_keep;
                  r_eol   <= w_ld_eol;
                  r_last  <= w_ld_last;
                  r_valid <= 1'b1;
               end
               if (w_hs) begin
                  r_outer <= w_nxt_outer;
                  r_inner <= w_nxt_inner;
                  if (r_last) begin
                     r_data  <= '0;
                     r_keep  <= '0;
                     r_eol   <= 1'b0;
                     r_last  <= 1'b0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= FLUSH;
                  end
               end
            end
            FLUSH:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Only the col-major form reads the start-time port directly.
   logic w_unused;
   assign w_unused = w_cm_in;

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_keep  = r_keep;
   assign out_eol   = r_eol;
   assign out_last  = r_last;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cfg_err   = r_err;

endmodule

// File: tb/tb_matrix_piso_stream.sv
// Directed bench for matrix_piso_stream with LANES=1 and LANES=4 instances
// over a 4x6 matrix of 8-bit elements, C[r][c] = r*16 + c.
module tb_matrix_piso_stream;

   logic        clk = 1'b0;
   logic        rst, start1, start4, ready;
   logic [2:0]  cfg_m, cfg_n;
   logic [191:0] mat;
`ifdef COL_MAJOR_EN
   logic        cm;
`endif

   logic [7:0]  d1;
   logic        k1, v1, e1, l1, b1, dn1, er1;
   logic [31:0] d4;
   logic [3:0]  k4;
   logic        v4, e4, l4, b4, dn4, er4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_piso_stream #(.DATA_W(8), .MAX_M(4), .MAX_N(6), .LANES(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .cfg_m(cfg_m), .cfg_n(cfg_n), .matrix_C(mat),
`ifdef COL_MAJOR_EN
      .col_major(cm),
`endif
      .out_data(d1), .out_valid(v1), .out_ready(ready), .out_keep(k1), .out_eol(e1),
      .out_last(l1), .busy(b1), .done(dn1), .cfg_err(er1));

   matrix_piso_stream #(.DATA_W(8), .MAX_M(4), .MAX_N(6), .LANES(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .cfg_m(cfg_m), .cfg_n(cfg_n), .matrix_C(mat),
`ifdef COL_MAJOR_EN
      .col_major(cm),
`endif
      .out_data(d4), .out_valid(v4), .out_ready(ready), .out_keep(k4), .out_eol(e4),
      .out_last(l4), .busy(b4), .done(dn4), .cfg_err(er4));

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({d1, k1, v1, e1, l1, b1, dn1, er1} !== 15'd0) begin
         errors++; $display("FAIL reset_l1 got=%h exp=0", {d1, k1, v1, e1, l1, b1, dn1, er1});
      end
      checks++;
      if ({d4, k4, v4, e4, l4, b4, dn4, er4} !== 42'd0) begin
         errors++; $display("FAIL reset_l4 got=%h exp=0", {d4, k4, v4, e4, l4, b4, dn4, er4});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_row_major();
      int n = 0, cyc = 0, first = -1;
      logic [9:0] expv;
      ready = 1'b1;
      start1 = 1'b1; cfg_m = 3'd2; cfg_n = 3'd3;
      @(negedge clk); start1 = 1'b0;
      checks++;
      if (b1 !== 1'b1 || v1 !== 1'b0) begin
         errors++; $display("FAIL t1_entry busy=%b valid=%b exp busy=1 valid=0", b1, v1);
      end
      while (n < 6 && cyc < 30) begin
         @(negedge clk); cyc++;
         if (v1) begin
            if (first < 0) first = cyc;
            expv = {8'((n / 3) * 16 + n % 3), (n % 3) == 2, n == 5};
            checks++;
            if ({d1, e1, l1} !== expv || k1 !== 1'b1) begin
               errors++; $display("FAIL t1_beat%0d got=%h keep=%b exp=%h keep=1", n, {d1, e1, l1}, k1, expv);
            end
            n++;
         end
      end
      checks++;
      if (n != 6 || first != 1) begin
         errors++; $display("FAIL t1_count beats=%0d first=%0d exp beats=6 first=1", n, first);
      end
      @(negedge clk);
      checks++;
      if ({v1, dn1, b1} !== 3'b010) begin
         errors++; $display("FAIL t1_done valid,done,busy=%b exp=010", {v1, dn1, b1});
      end
      @(negedge clk);
      checks++;
      if (dn1 !== 1'b0) begin
         errors++; $display("FAIL t1_done_pulse done=%b exp=0", dn1);
      end
   endtask

   task automatic test_lanes4();
      int n = 0, cyc = 0;
      bit saw_err = 0;
      logic [37:0] expv;
      ready = 1'b1;
      start4 = 1'b1; cfg_m = 3'd2; cfg_n = 3'd6;
      @(negedge clk);
      // Restart attempt with a bad config while busy must be ignored.
      cfg_m = 3'd0;
      @(negedge clk); start4 = 1'b0;
      while (n < 4 && cyc < 30) begin
         if (er4) saw_err = 1;
         if (v4) begin
            case (n)
               0:       expv = {32'h03020100, 4'hf, 1'b0, 1'b0};
               1:       expv = {32'h00000504, 4'h3, 1'b1, 1'b0};
               2:       expv = {32'h13121110, 4'hf, 1'b0, 1'b0};
               default: expv = {32'h00001514, 4'h3, 1'b1, 1'b1};
            endcase
            checks++;
            if ({d4, k4, e4, l4} !== expv) begin
               errors++; $display("FAIL t2_beat%0d got=%h exp=%h", n, {d4, k4, e4, l4}, expv);
            end
            n++;
         end
         @(negedge clk); cyc++;
      end
      checks++;
      if (n != 4 || saw_err) begin
         errors++; $display("FAIL t2_count beats=%0d cfg_err_seen=%0d exp beats=4 cfg_err_seen=0", n, saw_err);
      end
      checks++;
      if ({v4, dn4, b4} !== 3'b010) begin
         errors++; $display("FAIL t2_done valid,done,busy=%b exp=010", {v4, dn4, b4});
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int n = 0, cyc = 0;
      bit stalled = 0;
      logic [9:0] prev = '0, expv;
      start1 = 1'b1; cfg_m = 3'd2; cfg_n = 3'd3;
      @(negedge clk); start1 = 1'b0;
      while (n < 6 && cyc < 80) begin
         @(negedge clk);
         ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         cyc++;
         if (stalled) begin
            checks++;
            if (v1 !== 1'b1 || {d1, e1, l1} !== prev) begin
               errors++; $display("FAIL t3_hold valid=%b got=%h exp valid=1 %h", v1, {d1, e1, l1}, prev);
            end
         end
         if (v1 && ready) begin
            expv = {8'((n / 3) * 16 + n % 3), (n % 3) == 2, n == 5};
            checks++;
            if ({d1, e1, l1} !== expv) begin
               errors++; $display("FAIL t3_beat%0d got=%h exp=%h", n, {d1, e1, l1}, expv);
            end
            n++;
            stalled = 0;
         end else if (v1) begin
            stalled = 1;
            prev = {d1, e1, l1};
         end
      end
      @(negedge clk);
      ready = 1'b1;
      checks++;
      if (n != 6 || {v1, dn1} !== 2'b01) begin
         errors++; $display("FAIL t3_end beats=%0d valid,done=%b exp beats=6 01", n, {v1, dn1});
      end
      @(negedge clk);
   endtask

   task automatic test_cfg_err();
      for (int t = 0; t < 3; t++) begin
         if (t == 2) begin start4 = 1'b1; cfg_m = 3'd5; cfg_n = 3'd2; end
         else begin start1 = 1'b1; cfg_m = (t == 0) ? 3'd0 : 3'd2; cfg_n = (t == 0) ? 3'd3 : 3'd7; end
         @(negedge clk); start1 = 1'b0; start4 = 1'b0;
         checks++;
         if ((t == 2 ? {er4, b4} : {er1, b1}) !== 2'b10) begin
            errors++; $display("FAIL t4_err%0d err,busy=%b exp=10", t, (t == 2) ? {er4, b4} : {er1, b1});
         end
         @(negedge clk);
         checks++;
         if ({er1, b1, v1, er4, b4, v4} !== 6'd0) begin
            errors++; $display("FAIL t4_after%0d flags=%b exp=000000", t, {er1, b1, v1, er4, b4, v4});
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0, cyc = 0;
      logic [9:0] expv;
      ready = 1'b1;
      start1 = 1'b1; cfg_m = 3'd3; cfg_n = 3'd3;
      @(negedge clk); start1 = 1'b0;
      while (n < 2 && cyc < 20) begin
         @(negedge clk); cyc++;
         if (v1) n++;
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({d1, k1, v1, e1, l1, b1, dn1, er1} !== 15'd0 || n != 2) begin
         errors++; $display("FAIL t5_abort got=%h beats=%0d exp=0 beats=2", {d1, k1, v1, e1, l1, b1, dn1, er1}, n);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({v1, b1, dn1} !== 3'b000) begin
         errors++; $display("FAIL t5_idle valid,busy,done=%b exp=000", {v1, b1, dn1});
      end
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      n = 0; cyc = 0;
      while (n < 9 && cyc < 40) begin
         @(negedge clk); cyc++;
         if (v1) begin
            expv = {8'((n / 3) * 16 + n % 3), (n % 3) == 2, n == 8};
            checks++;
            if ({d1, e1, l1} !== expv) begin
               errors++; $display("FAIL t5_beat%0d got=%h exp=%h", n, {d1, e1, l1}, expv);
            end
            n++;
         end
      end
      @(negedge clk);
      checks++;
      if (n != 9 || dn1 !== 1'b1) begin
         errors++; $display("FAIL t5_done beats=%0d done=%b exp beats=9 done=1", n, dn1);
      end
      @(negedge clk);
   endtask

`ifdef COL_MAJOR_EN
   task automatic test_col_major();
      int n = 0, cyc = 0;
      logic [9:0] expv;
      ready = 1'b1; cm = 1'b1;
      start1 = 1'b1; cfg_m = 3'd2; cfg_n = 3'd3;
      @(negedge clk); start1 = 1'b0; cm = 1'b0;
      while (n < 6 && cyc < 30) begin
         @(negedge clk); cyc++;
         if (v1) begin
            expv = {8'((n % 2) * 16 + n / 2), (n % 2) == 1, n == 5};
            checks++;
            if ({d1, e1, l1} !== expv) begin
               errors++; $display("FAIL t6_beat%0d got=%h exp=%h", n, {d1, e1, l1}, expv);
            end
            n++;
         end
      end
      @(negedge clk);
      checks++;
      if (n != 6 || dn1 !== 1'b1) begin
         errors++; $display("FAIL t6_done beats=%0d done=%b exp beats=6 done=1", n, dn1);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      rst = 1'b1; start1 = 1'b0; start4 = 1'b0; ready = 1'b0;
      cfg_m = '0; cfg_n = '0;
`ifdef COL_MAJOR_EN
      cm = 1'b0;
`endif
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 6; c++)
            mat[(r * 6 + c) * 8 +: 8] = 8'(r * 16 + c);
      @(negedge clk);
      test_reset();
      test_row_major();
      test_lanes4();
      test_backpressure();
      test_cfg_err();
      test_reset_mid();
`ifdef COL_MAJOR_EN
      test_col_major();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
